dmem_arbiter: RTL and testbench

Two-requester arbiter sharing the single-port 32x64k data memory between master 0 (load/store unit) and master 1 (debug/DMA port). Each master presents base/offset/data/store with a valid/ready handshake. The arbiter forms the effective address, grants one access per cycle, drives the memory port and routes read data back to the issuing master one cycle later. Arbitration is round-robin with bounded bursts, so a streaming master cannot starve the other.

---
 rtl/dmem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter for the shared single-port 32x64k data memory.
// Round-robin between an idle start and bounded bursts, so neither master can starve
// the other. Effective address = base + offset (wraps at 32 bits). Load data comes
// back one cycle after the grant, flagged to the master that issued it.
// Optional feature: define DMEM_ARB_STATS_EN to add saturating per-master
// accepted-transfer counters (m0_count / m1_count).
module dmem_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  input  logic        m0_store,
  input  logic [31:0] m0_base,
  input  logic [31:0] m0_offset,
  input  logic [31:0] m0_data,
  output logic        m0_ready,
  output logic        m0_rvalid,
  output logic [31:0] m0_result,
  input  logic        m1_valid,
  input  logic        m1_store,
  input  logic [31:0] m1_base,
  input  logic [31:0] m1_offset,
  input  logic [31:0] m1_data,
  output logic        m1_ready,
  output logic        m1_rvalid,
  output logic [31:0] m1_result,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0] m0_count,
  output logic [15:0] m1_count,
`endif
  output logic [31:0] mem_A,
  output logic        mem_W,
  output logic [31:0] mem_D,
  input  logic [31:0] mem_Q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        rr_reg, rr_next;
  logic [1:0]  rd_pend_reg, rd_pend_next;
  logic [1:0]  grant;
  logic [3:0]  cnt_inc;
  logic [31:0] addr0, addr1;

  assign addr0 = m0_base + m0_offset;
  assign addr1 = m1_base + m1_offset;

  // The burst count only matters up to the limit (cnt < limit is all that is
  // asked), so hold it there instead of letting a long solo stream wrap it
  // back below the limit and hand the owner extra grants.
  assign cnt_inc = (cnt_reg >= BURST_LIMIT) ? cnt_reg : cnt_reg + 4'd1;

  // Arbiter state register; reset discards any pending read return.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= 4'd0;
      rr_reg      <= 1'b0;
      rd_pend_reg <= 2'b00;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      rr_reg      <= rr_next;
      rd_pend_reg <= rd_pend_next;
    end
  end

  // Grant selection from state and valids, plus next-state for owner/burst/pointer.
  always_comb begin
    grant        = 2'b00;
    state_next   = IDLE;
    cnt_next     = 4'd0;
    rr_next      = rr_reg;
    rd_pend_next = 2'b00;

    case (state_reg)
      OWN0: begin
        if (m0_valid && (!m1_valid || cnt_reg < BURST_LIMIT)) grant = 2'b01;
        else if (m1_valid)                                      grant = 2'b10;
      end
      OWN1: begin
        if (m1_valid && (!m0_valid || cnt_reg < BURST_LIMIT)) grant = 2'b10;
        else if (m0_valid)                                      grant = 2'b01;
      end
      default: begin
        if (m0_valid && m1_valid) grant = rr_reg ? 2'b10 : 2'b01;
        else                      grant = {m1_valid, m0_valid};
      end
    endcase

    // No handshakes complete while reset is held.
    if (!rst) grant = 2'b00;

    if (grant[0]) begin
      state_next      = OWN0;
      cnt_next        = (state_reg == OWN0) ? cnt_inc : 4'd1;
      rr_next         = 1'b1;
      rd_pend_next[0] = !m0_store;
    end else if (grant[1]) begin
      state_next      = OWN1;
      cnt_next        = (state_reg == OWN1) ? cnt_inc : 4'd1;
      rr_next         = 1'b0;
      rd_pend_next[1] = !m1_store;
    end
  end

  // Memory port drive; with no grant the address/data idle on master 0's fields.
  always_comb begin
    mem_A = addr0;
    mem_D = m0_data;
    mem_W = 1'b0;
    if (grant[1]) begin
      mem_A = addr1;
      mem_D = m1_data;
      mem_W = m1_store;
    end else if (grant[0]) begin
      mem_W = m0_store;
    end
  end

  assign m0_ready  = grant[0];
  assign m1_ready  = grant[1];
  assign m0_rvalid = rd_pend_reg[0];
  assign m1_rvalid = rd_pend_reg[1];
  assign m0_result = mem_Q;
  assign m1_result = mem_Q;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_reg  [2];
  logic [15:0] stat_next [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_stat
      assign stat_next[gi] = (grant[gi] && stat_reg[gi] != 16'hFFFF)
                             ? stat_reg[gi] + 16'd1 : stat_reg[gi];
    end
  endgenerate

  // Saturating accepted-transfer counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_reg[0] <= 16'd0;
      stat_reg[1] <= 16'd0;
    end else begin
      stat_reg[0] <= stat_next[0];
      stat_reg[1] <= stat_next[1];
    end
  end

  assign m0_count = stat_reg[0];
  assign m1_count = stat_reg[1];
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: hand-derived vector table, reset/contention sequences and a
// randomized run checked against an owner/run-length reference model.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int   MAXB = 4;
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;
  localparam logic [31:0] Z = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_valid = 1'b0, m0_store = 1'b0;
  logic [31:0] m0_base = '0, m0_offset = '0, m0_data = '0;
  logic        m1_valid = 1'b0, m1_store = 1'b0;
  logic [31:0] m1_base = '0, m1_offset = '0, m1_data = '0;
  logic        m0_ready, m0_rvalid, m1_ready, m1_rvalid;
  logic [31:0] m0_result, m1_result;
  logic [31:0] mem_A, mem_D;
  logic [31:0] mem_Q = '0;
  logic        mem_W;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] m0_count, m1_count;
`endif

  dmem_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_store(m0_store), .m0_base(m0_base),
    .m0_offset(m0_offset), .m0_data(m0_data), .m0_ready(m0_ready),
    .m0_rvalid(m0_rvalid), .m0_result(m0_result),
    .m1_valid(m1_valid), .m1_store(m1_store), .m1_base(m1_base),
    .m1_offset(m1_offset), .m1_data(m1_data), .m1_ready(m1_ready),
    .m1_rvalid(m1_rvalid), .m1_result(m1_result),
`ifdef DMEM_ARB_STATS_EN
    .m0_count(m0_count), .m1_count(m1_count),
`endif
    .mem_A(mem_A), .mem_W(mem_W), .mem_D(mem_D), .mem_Q(mem_Q)
  );

  always #5 clk = ~clk;

  // Single-port synchronous memory, 64k words, registered read.
  logic [31:0] mem_arr [0:65535];
  initial for (int i = 0; i < 65536; i++) mem_arr[i] = '0;
  always @(posedge clk) begin
    if (mem_W) mem_arr[mem_A[15:0]] <= mem_D;
    mem_Q <= mem_arr[mem_A[15:0]];
  end

  typedef struct {
    logic v0, s0; logic [31:0] b0, o0, d0;
    logic v1, s1; logic [31:0] b1, o1, d1;
  } req_t;
  typedef struct {
    logic r0, r1; logic [31:0] a; logic w; logic [31:0] d;
    logic rv0, rv1; logic [31:0] res;
  } obs_t;
  typedef struct { req_t rq; obs_t ex; } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who owns the port, how long its current run is, who wins a tie.
  int          own = -1, run = 0, fav = 0;
  logic [1:0]  pend = 2'b00;
  logic [31:0] pend_data = '0;
  logic [31:0] mdl_mem [logic [15:0]];
  int unsigned mcnt [2] = '{0, 0};

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
  endtask

  function automatic req_t mk(input logic v0, s0, input logic [31:0] b0, o0, d0,
                              input logic v1, s1, input logic [31:0] b1, o1, d1);
    req_t r;
    r.v0 = v0; r.s0 = s0; r.b0 = b0; r.o0 = o0; r.d0 = d0;
    r.v1 = v1; r.s1 = s1; r.b1 = b1; r.o1 = o1; r.d1 = d1;
    return r;
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [15:0] a);
    return mdl_mem.exists(a) ? mdl_mem[a] : 32'h0;
  endfunction

  task automatic model_reset();
    own = -1; run = 0; fav = 0; pend = 2'b00;
    mcnt[0] = 0; mcnt[1] = 0;
  endtask

  // One cycle: drive, sample mid-cycle, compare with the model, advance.
  task automatic step(input req_t rq, output obs_t ob);
    int g;
    logic [31:0] ea, ed;
    logic ew;
    m0_valid = rq.v0; m0_store = rq.s0; m0_base = rq.b0; m0_offset = rq.o0; m0_data = rq.d0;
    m1_valid = rq.v1; m1_store = rq.s1; m1_base = rq.b1; m1_offset = rq.o1; m1_data = rq.d1;
    @(negedge clk);
    ob.r0 = m0_ready; ob.r1 = m1_ready; ob.a = mem_A; ob.w = mem_W; ob.d = mem_D;
    ob.rv0 = m0_rvalid; ob.rv1 = m1_rvalid; ob.res = m0_result;

    g = -1;
    if (rq.v0 && !rq.v1)      g = 0;
    else if (rq.v1 && !rq.v0) g = 1;
    else if (rq.v0 && rq.v1) begin
      if (own < 0)         g = fav;
      else if (run < MAXB) g = own;
      else                 g = 1 - own;
    end
    ea = (g == 1) ? rq.b1 + rq.o1 : rq.b0 + rq.o0;
    ed = (g == 1) ? rq.d1 : rq.d0;
    ew = (g == 0) ? rq.s0 : (g == 1) ? rq.s1 : 1'b0;

    chk1("ready0", ob.r0, g == 0);
    chk1("ready1", ob.r1, g == 1);
    chk32("mem_A", ob.a, ea);
    chk1("mem_W", ob.w, ew);
    chk32("mem_D", ob.d, ed);
    chk1("rvalid0", ob.rv0, pend[0]);
    chk1("rvalid1", ob.rv1, pend[1]);
    if (pend != 2'b00) begin
      chk32("result0", m0_result, pend_data);
      chk32("result1", m1_result, pend_data);
    end
`ifdef DMEM_ARB_STATS_EN
    chk32("count0", {16'h0, m0_count}, mcnt[0]);
    chk32("count1", {16'h0, m1_count}, mcnt[1]);
`endif

    pend = 2'b00;
    if (g >= 0) begin
      run = (g == own) ? run + 1 : 1;
      own = g;
      fav = 1 - g;
      if (mcnt[g] < 65535) mcnt[g]++;
      if (ew) mdl_mem[ea[15:0]] = ed;
      else begin
        pend[g]   = 1'b1;
        pend_data = mdl_rd(ea[15:0]);
      end
    end else begin
      own = -1;
      run = 0;
    end
    $display("cyc g=%0d A=%h W=%b rv=%b%b", g, ob.a, ob.w, ob.rv1, ob.rv0);
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset with requests pending; outputs must be quiet at once.
  task automatic do_reset();
    rst = 1'b0;
    m0_valid = 1'b1; m0_store = 1'b1; m1_valid = 1'b1; m1_store = 1'b1;
    #1;
    chk1("rst_ready0", m0_ready, 1'b0);
    chk1("rst_ready1", m1_ready, 1'b0);
    chk1("rst_mem_W", mem_W, 1'b0);
    chk1("rst_rvalid0", m0_rvalid, 1'b0);
    chk1("rst_rvalid1", m1_rvalid, 1'b0);
`ifdef DMEM_ARB_STATS_EN
    chk32("rst_count0", {16'h0, m0_count}, 32'h0);
    chk32("rst_count1", {16'h0, m1_count}, 32'h0);
`endif
    m0_valid = 1'b0; m1_valid = 1'b0; m0_store = 1'b0; m1_store = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic rand_side(output logic v, s, output logic [31:0] b, o, d);
    logic [31:0] tgt;
    v   = ($urandom_range(0, 9) < 7);
    s   = $urandom_range(0, 1) == 1;
    tgt = 32'($urandom_range(0, 15));
    b   = $urandom;
    o   = tgt - b;
    d   = $urandom;
  endtask

  vec_t tbl [15];
  obs_t ob;
  req_t cur, zr, rq;

  initial begin
    zr = mk(F, F, Z, Z, Z, F, F, Z, Z, Z);
    tbl[0]  = '{mk(T, T, 32'h100, 32'h4, 32'hDEADBEEF, F, F, Z, Z, Z),
                '{T, F, 32'h104, T, 32'hDEADBEEF, F, F, Z}};
    tbl[1]  = '{mk(T, F, 32'h100, 32'h4, Z, F, F, Z, Z, Z),
                '{T, F, 32'h104, F, Z, F, F, Z}};
    tbl[2]  = '{zr, '{F, F, Z, F, Z, T, F, 32'hDEADBEEF}};
    tbl[3]  = '{mk(F, F, Z, Z, Z, T, F, 32'hFFFFFFFC, 32'h8, 32'h11),
                '{F, T, 32'h4, F, 32'h11, F, F, Z}};
    tbl[4]  = '{mk(F, F, Z, Z, Z, T, T, 32'h200, Z, 32'hCAFEF00D),
                '{F, T, 32'h200, T, 32'hCAFEF00D, F, T, Z}};
    tbl[5]  = '{mk(T, F, 32'h1F0, 32'h10, Z, F, F, Z, Z, Z),
                '{T, F, 32'h200, F, Z, F, F, Z}};
    tbl[6]  = '{mk(F, F, Z, Z, Z, T, F, 32'h100, 32'h4, Z),
                '{F, T, 32'h104, F, Z, T, F, 32'hCAFEF00D}};
    tbl[7]  = '{zr, '{F, F, Z, F, Z, F, T, 32'hDEADBEEF}};
    tbl[8]  = '{mk(T, F, Z, Z, Z, T, F, 32'h104, Z, Z),
                '{T, F, Z, F, Z, F, F, Z}};
    tbl[9]  = '{mk(F, F, Z, Z, Z, T, F, 32'h104, Z, Z),
                '{F, T, 32'h104, F, Z, T, F, Z}};
    for (int i = 10; i < 13; i++)
      tbl[i] = '{mk(T, F, 32'h200, Z, Z, T, F, 32'h104, Z, Z),
                 '{F, T, 32'h104, F, Z, F, T, 32'hDEADBEEF}};
    tbl[10].ex.rv1 = T;
    tbl[13] = '{mk(T, F, 32'h200, Z, Z, T, F, 32'h104, Z, Z),
                '{T, F, 32'h200, F, Z, F, T, 32'hDEADBEEF}};
    tbl[14] = '{zr, '{F, F, Z, F, Z, T, F, 32'hCAFEF00D}};

    do_reset();

    // Hand-derived vectors: store/load, wrap, handoff, burst limit.
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rq, ob);
      chk1($sformatf("tbl%0d_ready0", i), ob.r0, tbl[i].ex.r0);
      chk1($sformatf("tbl%0d_ready1", i), ob.r1, tbl[i].ex.r1);
      chk32($sformatf("tbl%0d_mem_A", i), ob.a, tbl[i].ex.a);
      chk1($sformatf("tbl%0d_mem_W", i), ob.w, tbl[i].ex.w);
      chk32($sformatf("tbl%0d_mem_D", i), ob.d, tbl[i].ex.d);
      chk1($sformatf("tbl%0d_rvalid0", i), ob.rv0, tbl[i].ex.rv0);
      chk1($sformatf("tbl%0d_rvalid1", i), ob.rv1, tbl[i].ex.rv1);
      if (tbl[i].ex.rv0 || tbl[i].ex.rv1)
        chk32($sformatf("tbl%0d_result", i), ob.res, tbl[i].ex.res);
    end

    // Contention from reset: m0 x4, m1 x4, m0 x4, one grant every cycle.
    do_reset();
    rq = mk(T, F, 32'h10, Z, Z, T, F, 32'h20, Z, Z);
    for (int i = 0; i < 12; i++) begin
      step(rq, ob);
      chk1($sformatf("contend%0d_ready0", i), ob.r0, ((i / 4) % 2) == 0);
      chk1($sformatf("contend%0d_ready1", i), ob.r1, ((i / 4) % 2) == 1);
    end

    // Reset while a load return is pending; a store held during reset is dropped.
    do_reset();
    step(mk(T, T, 32'h300, Z, 32'h55, F, F, Z, Z, Z), ob);
    step(mk(F, F, Z, Z, Z, T, F, 32'h104, Z, Z), ob);
    chk1("midrd_grant1", ob.r1, 1'b1);
    rst = 1'b0;
    m1_valid = 1'b0;
    m0_valid = 1'b1; m0_store = 1'b1; m0_base = 32'h400; m0_offset = Z; m0_data = 32'h77;
    #1;
    chk1("midrd_rvalid1", m1_rvalid, 1'b0);
    chk1("midrd_mem_W", mem_W, 1'b0);
    @(posedge clk);
    #1;
    m0_valid = 1'b0; m0_store = 1'b0;
    rst = 1'b1;
    model_reset();
    step(mk(T, F, 32'h400, Z, Z, T, F, 32'h104, Z, Z), ob);
    chk1("post_rst_m0_first", ob.r0, 1'b1);
    chk1("post_rst_rvalid1", ob.rv1, 1'b0);
    step(zr, ob);
    chk32("rst_store_dropped", ob.res, 32'h0);

    // Randomized traffic; a stalled request keeps its fields.
    cur = zr;
    for (int i = 0; i < 2000; i++) begin
      if (!(cur.v0 && !ob.r0)) rand_side(cur.v0, cur.s0, cur.b0, cur.o0, cur.d0);
      if (!(cur.v1 && !ob.r1)) rand_side(cur.v1, cur.s1, cur.b1, cur.o1, cur.d1);
      step(cur, ob);
    end

`ifdef DMEM_ARB_STATS_EN
    // Counter saturation, then clear on reset.
    do_reset();
    m0_valid = 1'b1; m0_store = 1'b0; m0_base = 32'h10; m0_offset = Z;
    repeat (65540) @(posedge clk);
    #1;
    m0_valid = 1'b0;
    m1_valid = 1'b1; m1_store = 1'b0; m1_base = 32'h20; m1_offset = Z;
    repeat (3) @(posedge clk);
    #1;
    m1_valid = 1'b0;
    @(negedge clk);
    chk32("sat_count0", {16'h0, m0_count}, 32'hFFFF);
    chk32("sat_count1", {16'h0, m1_count}, 32'h3);
    @(posedge clk);
    #1;
    do_reset();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
